// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle for regfile_wr_arbiter: pipeline writer A, buffered writer B, and the
// registered register-file write outputs. busy_mask exists only with REGARB_BUSY_MASK_EN.
interface regfile_wr_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          a_we;
    logic [4:0]    a_wn;
    logic [31:0]   a_d;
    logic          a_stall;
    logic          b_valid;
    logic [4:0]    b_wn;
    logic [31:0]   b_d;
    logic          b_ready;
    logic [CW-1:0] b_count;
    logic [4:0]    wn;
    logic [31:0]   d;
    logic          we;
`ifdef REGARB_BUSY_MASK_EN
    logic [31:0]   busy_mask;
`endif

    modport master (
        output a_we, a_wn, a_d, b_valid, b_wn, b_d,
`ifdef REGARB_BUSY_MASK_EN
        input  busy_mask,
`endif
        input  a_stall, b_ready, b_count, wn, d, we
    );

    modport slave (
        input  a_we, a_wn, a_d, b_valid, b_wn, b_d,
`ifdef REGARB_BUSY_MASK_EN
        output busy_mask,
`endif
        output a_stall, b_ready, b_count, wn, d, we
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between priority port A and a FIFO-buffered port B,
// forcing a B drain after STARVE_LIMIT waiting cycles. Optional busy_mask: REGARB_BUSY_MASK_EN.
module regfile_wr_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 Clrn,
    regfile_wr_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StNormal, StForce} state_e;

    state_e        state_q, state_d;
    logic [4:0]    mem_wn_q [DEPTH];
    logic [4:0]    mem_wn_d [DEPTH];
    logic [31:0]   mem_d_q  [DEPTH];
    logic [31:0]   mem_d_d  [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic [4:0]    wn_q, wn_d;
    logic [31:0]   d_q, d_d;

    logic empty, full, push, pop, a_req, grant_a;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        push    = bus.b_valid && !full;
        a_req   = bus.a_we && (bus.a_wn != 5'd0);
        grant_a = 1'b0;
        pop     = 1'b0;
        // FORCE is only entered with a non-empty FIFO, so it always has a head to drain
        if (state_q == StForce) begin
            pop = !empty;
        end else if (a_req) begin
            grant_a = 1'b1;
        end else begin
            pop = !empty;
        end

        starve_d = (pop || empty) ? '0 : starve_q + SW'(1);
        state_d  = StNormal;
        if (state_q == StNormal && starve_d == SW'(STARVE_LIMIT)) state_d = StForce;

        mem_wn_d = mem_wn_q;
        mem_d_d  = mem_d_q;
        if (push) begin
            mem_wn_d[wptr_q] = bus.b_wn;
            mem_d_d[wptr_q]  = bus.b_d;
        end
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);

        we_d = 1'b0;
        wn_d = wn_q;
        d_d  = d_q;
        if (grant_a) begin
            we_d = 1'b1;
            wn_d = bus.a_wn;
            d_d  = bus.a_d;
        end else if (pop) begin
            we_d = (mem_wn_q[rptr_q] != 5'd0);
            wn_d = mem_wn_q[rptr_q];
            d_d  = mem_d_q[rptr_q];
        end
    end

    always_ff @(posedge clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q  <= StNormal;
            for (int i = 0; i < DEPTH; i++) begin
                mem_wn_q[i] <= '0;
                mem_d_q[i]  <= '0;
            end
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            wn_q     <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            mem_wn_q <= mem_wn_d;
            mem_d_q  <= mem_d_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wn_q     <= wn_d;
            d_q      <= d_d;
        end
    end

    assign bus.a_stall = (state_q == StForce) && bus.a_we;
    assign bus.b_ready = !full;
    assign bus.b_count = count_q;
    assign bus.we      = we_q;
    assign bus.wn      = wn_q;
    assign bus.d       = d_q;

`ifdef REGARB_BUSY_MASK_EN
    logic [31:0]   busy_mask;
    logic [PW-1:0] idx;
    always_comb begin
        busy_mask = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if (CW'(i) < count_q) busy_mask[mem_wn_q[idx]] = 1'b1;
        end
        if (we_q) busy_mask[wn_q] = 1'b1;
        busy_mask[0] = 1'b0;
    end
    assign bus.busy_mask = busy_mask;
`endif
endmodule
